raster_multi: RTL and testbench
===============================

Name: raster_multi

Overview:
- Parametrised successor to the single-triangle scanline rasteriser.
- Evaluates N_TRI triangles in parallel against the VGA beam using incremental edge functions and per-triangle barycentric (Q2.F) interpolators.
- Resolves the winner per pixel by fixed index priority and shades it flat, textured or back-facing.
- Drives the shared texture ROM address and emits 6-bit RGB to top. Sits between the vertex-setup stage (VS) and the VGA output.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- H_TOTAL, 800, pixels per line incl. blanking
- V_TOTAL, 525, lines per frame
- EW, 20, signed edge-function width
- BW, 22, signed barycentric width, Q2.(BW-2)
- TEX_BITS, 7, texture coordinate bits per axis
- N_TRI, 2, number of triangles (1..4)
- PIX_DIV, 2, clocks per pixel (2..4)

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-low (0 = reset)
- x  in  10  beam column from vga
- y  in  10  beam row from vga
- cull_back  in  1  1 = back-facing triangles never drawn
- tri_mode  in  2*N_TRI  per triangle: 00 off, 01 flat, 10 textured, 11 reserved (treated as off)
- tri_color  in  3*N_TRI  per-triangle intensity index 0..7
- edge_dx  in  EW*3*N_TRI  per-edge x-increment (a0,a1,a2 per triangle, signed)
- e_init  in  EW*3*N_TRI  per-edge value at pixel 0 of the next line/frame
- bar_iy, bar_iz  in  BW*N_TRI each  barycentric start values
- bar_iy_dx, bar_iz_dx  in  BW*N_TRI each  barycentric x-increments
- tex_u, tex_v  out  TEX_BITS each  texture address of the current winner (combinational)
- texel  in  1  ROM data for tex_u/tex_v, same cycle
- rgb  out  6  registered pixel colour
- hit_tri  out  2  registered index of the winning triangle
- hit_valid  out  1  registered, 1 = some triangle covered this pixel

Behaviour:
- Reset (asynchronous, reset=0): all edge, barycentric and u/v registers = 0; phase = PIX_DIV-1; rgb = 0; hit_tri = 0; hit_valid = 0.
- Reload happens when x==H_TOTAL-1 and (y<V_ACTIVE or y==V_TOTAL-1). For every triangle:
  - e_k <= e_init_k
  - b_iy <= bar_iy, b_iz <= bar_iz
  - phase <= PIX_DIV-1
  - Reload has priority over all pixel activity.
- Pixel activity occurs only while x<H_ACTIVE and y<V_ACTIVE. Outside that window all registers hold, including rgb.
- Phase 0 (all triangles):
  - b_iy += bar_iy_dx; b_iz += bar_iz_dx
  - ui <= new b_iy + new b_iz; vi <= new b_iy
  - All arithmetic wraps at BW bits.
  - phase <= 1.
- Phases 1..PIX_DIV-2: hold, phase += 1.
- Phase PIX_DIV-1, shading:
  - front_i = all three e < 0 (strict); back_i = all three e > 0. Any e == 0 is outside. Triangles in mode off or 11 never cover.
  - Winner = lowest-index front_i.
  - If there is none and cull_back==0, winner = lowest-index back_i.
  - rgb, hit_tri and hit_valid are updated in this phase.
- Shading of the winner:
  - Front, flat: colour 0..7 maps to 000000, 000100, 001000, 001000, 001100, 001100, 011101, 101110.
  - Front, textured: rgb = texel ? 001100 : 000000.
  - Back (any mode): colour 0..7 maps to 000000, 000001, 000010, 000010, 000011, 000011, 010111, 101011.
  - No winner: rgb = 010101, hit_valid = 0, hit_tri = 0.
  - Then every e_k += edge_dx_k (wraps at EW bits), and phase <= 0.
- tex_u = winner ui[BW-3 -: TEX_BITS]; tex_v = winner vi[BW-3 -: TEX_BITS]. With no winner, triangle 0's u/v are driven. These are valid in every phase.
- Reset asserted mid-line takes effect immediately. After release, pixels are wrong until the next reload; the next line/frame renders correctly.
- Inputs are sampled live. VS must hold edge_dx and the bar_*_dx values stable across a line, and e_init/bar_* stable at x==H_TOTAL-1.

Test Plan:
- Reset with reset=0 mid-line, release, then run to the frame reload (y=524, x=799) -> rgb=0 before the first active pixel; after reload, pixel 0 of line 0 is shaded from e_init.
- N_TRI=1, flat, color=6, e_init={-5,-5,-5}, edge_dx={0,0,0} -> every visible pixel rgb=011101, hit_valid=1, hit_tri=0; rgb changes only on phase PIX_DIV-1 clocks.
- Tri0 e_init={-1,-1,-1}, edge_dx={1,0,0} -> pixel 0 covered; pixel 1 has e0=0 and shows background 010101.
- Both triangles front-covered, tri0 flat color 4, tri1 flat color 7 -> rgb=001100, hit_tri=0. Set tri0 mode=00 -> rgb=101110, hit_tri=1.
- Tri0 back-facing {3,3,3} color 7, tri1 off -> cull_back=0 gives 101011; cull_back=1 gives 010101 with hit_valid=0.
- Textured, BW=22, bar_iy=0, bar_iy_dx=0x2000, bar_iz=0, bar_iz_dx=0 -> tex_v = tex_u = 1 at pixel 0 and increments by 1 per pixel; texel=1 gives 001100 and texel=0 gives 000000. Repeat with PIX_DIV=3 to confirm one pixel per 3 clocks.

Source files
------------

// File: rtl/raster_multi_if.sv
// raster_multi_if: triangle setup bus from vertex setup, plus the shared
// texture ROM port.
//   master : vertex-setup / ROM side. Drives the per-triangle setup and texel.
//            Receives tex_u/tex_v.
//   slave  : rasteriser side.
// Packing (t = triangle, k = edge 0..2):
//   tri_mode  [2t +: 2]
//   tri_color [3t +: 3]
//   edge_dx/e_init [(3t+k)*EW +: EW]
//   bar_*     [t*BW +: BW]
interface raster_multi_if #(
  parameter int EW       = 20,
  parameter int BW       = 22,
  parameter int TEX_BITS = 7,
  parameter int N_TRI    = 2
);
  logic [2*N_TRI-1:0]    tri_mode;
  logic [3*N_TRI-1:0]    tri_color;
  logic [EW*3*N_TRI-1:0] edge_dx;
  logic [EW*3*N_TRI-1:0] e_init;
  logic [BW*N_TRI-1:0]   bar_iy;
  logic [BW*N_TRI-1:0]   bar_iz;
  logic [BW*N_TRI-1:0]   bar_iy_dx;
  logic [BW*N_TRI-1:0]   bar_iz_dx;
  logic [TEX_BITS-1:0]   tex_u;
  logic [TEX_BITS-1:0]   tex_v;
  logic                  texel;

  modport master (
    output tri_mode, tri_color, edge_dx, e_init,
    output bar_iy, bar_iz, bar_iy_dx, bar_iz_dx, texel,
    input  tex_u, tex_v
  );

  modport slave (
    input  tri_mode, tri_color, edge_dx, e_init,
    input  bar_iy, bar_iz, bar_iy_dx, bar_iz_dx, texel,
    output tex_u, tex_v
  );
endinterface

// File: rtl/raster_multi.sv
// raster_multi: scanline rasteriser for N_TRI triangles in parallel.
// Incremental edge functions and barycentric (Q2.(BW-2)) interpolators are
// kept per triangle. The winner per pixel is chosen by fixed index
// priority, with front faces taking priority over back faces. The winner is
// shaded flat, textured or back-facing.
// Ports:
//   clk        pixel-domain clock
//   reset      asynchronous, active-low
//   x, y       beam position from the VGA timing generator
//   cull_back  1 = back-facing triangles are never drawn
//   vs         setup bus and texture ROM port (raster_multi_if.slave)
//   rgb        registered 6-bit pixel colour
//   hit_tri    registered winning triangle index
//   hit_valid  registered, 1 = some triangle covered the pixel
module raster_multi #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int EW       = 20,
  parameter int BW       = 22,
  parameter int TEX_BITS = 7,
  parameter int N_TRI    = 2,
  parameter int PIX_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       cull_back,
  raster_multi_if.slave vs,
  output logic [5:0] rgb,
  output logic [1:0] hit_tri,
  output logic       hit_valid
);

  localparam logic [9:0] X_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);
  localparam logic [1:0] PH_LAST = 2'(PIX_DIV - 1);

  logic [EW-1:0] e_q    [N_TRI][3];
  logic [BW-1:0] biy_q  [N_TRI];
  logic [BW-1:0] biz_q  [N_TRI];
  logic [BW-1:0] ui_q   [N_TRI];
  logic [BW-1:0] vi_q   [N_TRI];
  logic [BW-1:0] biy_nx [N_TRI];
  logic [BW-1:0] biz_nx [N_TRI];
  logic [1:0]    phase_q;

  logic [N_TRI-1:0] front, back;
  logic             win_valid, win_front;
  logic [1:0]       win_idx;
  logic [1:0]       win_mode;
  logic [2:0]       win_color;
  logic [BW-1:0]    u_sel, v_sel;
  logic [5:0]       rgb_d;
  logic             reload, pix_active;
  logic             unused_uv;

  function automatic logic [5:0] front_lut(input logic [2:0] c);
    case (c)
      3'd0:    front_lut = 6'b000000;
      3'd1:    front_lut = 6'b000100;
      3'd2:    front_lut = 6'b001000;
      3'd3:    front_lut = 6'b001000;
      3'd4:    front_lut = 6'b001100;
      3'd5:    front_lut = 6'b001100;
      3'd6:    front_lut = 6'b011101;
      default: front_lut = 6'b101110;
    endcase
  endfunction

  function automatic logic [5:0] back_lut(input logic [2:0] c);
    case (c)
      3'd0:    back_lut = 6'b000000;
      3'd1:    back_lut = 6'b000001;
      3'd2:    back_lut = 6'b000010;
      3'd3:    back_lut = 6'b000010;
      3'd4:    back_lut = 6'b000011;
      3'd5:    back_lut = 6'b000011;
      3'd6:    back_lut = 6'b010111;
      default: back_lut = 6'b101011;
    endcase
  endfunction

  assign reload     = (x == X_LAST) && ((y < Y_ACT) || (y == Y_LAST));
  assign pix_active = (x < X_ACT) && (y < Y_ACT);

  always_comb begin
    for (int t = 0; t < N_TRI; t++) begin
      biy_nx[t] = biy_q[t] + vs.bar_iy_dx[t*BW +: BW];
      biz_nx[t] = biz_q[t] + vs.bar_iz_dx[t*BW +: BW];
    end
  end

  // Coverage: an edge value of exactly zero counts as outside for both faces.
  // Mode 11 is reserved and behaves like off.
  always_comb begin
    front = '0;
    back  = '0;
    for (int t = 0; t < N_TRI; t++) begin
      if (vs.tri_mode[2*t +: 2] == 2'b01 || vs.tri_mode[2*t +: 2] == 2'b10) begin
        front[t] = e_q[t][0][EW-1] & e_q[t][1][EW-1] & e_q[t][2][EW-1];
        back[t]  = ~e_q[t][0][EW-1] & (|e_q[t][0]) &
                   ~e_q[t][1][EW-1] & (|e_q[t][1]) &
                   ~e_q[t][2][EW-1] & (|e_q[t][2]);
      end
    end
  end

  // Descending scan so the lowest index is written last and wins.
  always_comb begin
    win_valid = 1'b0;
    win_front = 1'b0;
    win_idx   = 2'd0;
    for (int t = N_TRI - 1; t >= 0; t--) begin
      if (front[t]) begin
        win_valid = 1'b1;
        win_front = 1'b1;
        win_idx   = 2'(t);
      end
    end
    if (!win_valid && !cull_back) begin
      for (int t = N_TRI - 1; t >= 0; t--) begin
        if (back[t]) begin
          win_valid = 1'b1;
          win_idx   = 2'(t);
        end
      end
    end
  end

  // With no winner, win_idx is 0, so triangle 0 drives the texture address.
  always_comb begin
    win_mode  = vs.tri_mode[1:0];
    win_color = vs.tri_color[2:0];
    u_sel     = ui_q[0];
    v_sel     = vi_q[0];
    for (int t = 1; t < N_TRI; t++) begin
      if (win_idx == 2'(t)) begin
        win_mode  = vs.tri_mode[2*t +: 2];
        win_color = vs.tri_color[3*t +: 3];
        u_sel     = ui_q[t];
        v_sel     = vi_q[t];
      end
    end
  end

  assign vs.tex_u  = u_sel[BW-3 -: TEX_BITS];
  assign vs.tex_v  = v_sel[BW-3 -: TEX_BITS];
  assign unused_uv = ^{u_sel, v_sel};

  always_comb begin
    rgb_d = 6'b010101;
    if (win_valid) begin
      if (!win_front)
        rgb_d = back_lut(win_color);
      else if (win_mode == 2'b10)
        rgb_d = vs.texel ? 6'b001100 : 6'b000000;
      else
        rgb_d = front_lut(win_color);
    end
  end

  // Pixel cycle: phase 0 steps the interpolators, the middle phases wait,
  // and the last phase shades and steps the edges. A reload parks the
  // counter on the last phase, so the first visible clock shades from e_init.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < N_TRI; t++) begin
        for (int k = 0; k < 3; k++) e_q[t][k] <= '0;
        biy_q[t] <= '0;
        biz_q[t] <= '0;
        ui_q[t]  <= '0;
        vi_q[t]  <= '0;
      end
      phase_q   <= PH_LAST;
      rgb       <= '0;
      hit_tri   <= '0;
      hit_valid <= 1'b0;
    end else if (reload) begin
      for (int t = 0; t < N_TRI; t++) begin
        for (int k = 0; k < 3; k++) e_q[t][k] <= vs.e_init[(3*t+k)*EW +: EW];
        biy_q[t] <= vs.bar_iy[t*BW +: BW];
        biz_q[t] <= vs.bar_iz[t*BW +: BW];
      end
      phase_q <= PH_LAST;
    end else if (pix_active) begin
      if (phase_q == PH_LAST) begin
        rgb       <= rgb_d;
        hit_tri   <= win_idx;
        hit_valid <= win_valid;
        for (int t = 0; t < N_TRI; t++)
          for (int k = 0; k < 3; k++)
            e_q[t][k] <= e_q[t][k] + vs.edge_dx[(3*t+k)*EW +: EW];
        phase_q <= 2'd0;
      end else if (phase_q == 2'd0) begin
        for (int t = 0; t < N_TRI; t++) begin
          biy_q[t] <= biy_nx[t];
          biz_q[t] <= biz_nx[t];
          ui_q[t]  <= biy_nx[t] + biz_nx[t];
          vi_q[t]  <= biy_nx[t];
        end
        phase_q <= 2'd1;
      end else begin
        phase_q <= phase_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_raster_multi.sv
// tb_raster_multi: directed bench for raster_multi.
// Instance A: N_TRI=2, PIX_DIV=2. Instance B: N_TRI=1, PIX_DIV=3.
// The beam is driven directly, so each line only runs the pixels of interest.
module tb_raster_multi;
  localparam int EW = 20;
  localparam int BW = 22;
  localparam int TB = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       cull_back;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [5:0] rgb_a, rgb_b;
  logic [1:0] ht_a, ht_b;
  logic       hv_a, hv_b;
  int         total, bad;

  always #5 clk = ~clk;

  raster_multi_if #(.EW(EW), .BW(BW), .TEX_BITS(TB), .N_TRI(2)) if_a ();
  raster_multi_if #(.EW(EW), .BW(BW), .TEX_BITS(TB), .N_TRI(1)) if_b ();

  raster_multi #(.EW(EW), .BW(BW), .TEX_BITS(TB), .N_TRI(2), .PIX_DIV(2)) u_a (
    .clk(clk), .reset(reset), .x(x_a), .y(y_a), .cull_back(cull_back),
    .vs(if_a.slave), .rgb(rgb_a), .hit_tri(ht_a), .hit_valid(hv_a)
  );

  raster_multi #(.EW(EW), .BW(BW), .TEX_BITS(TB), .N_TRI(1), .PIX_DIV(3)) u_b (
    .clk(clk), .reset(reset), .x(x_b), .y(y_b), .cull_back(cull_back),
    .vs(if_b.slave), .rgb(rgb_b), .hit_tri(ht_b), .hit_valid(hv_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int t, input logic [1:0] mode, input logic [2:0] col,
                       input int e0, input int e1, input int e2,
                       input int d0, input int d1, input int d2);
    if_a.tri_mode[2*t +: 2]          = mode;
    if_a.tri_color[3*t +: 3]         = col;
    if_a.e_init[(3*t+0)*EW +: EW]    = EW'(e0);
    if_a.e_init[(3*t+1)*EW +: EW]    = EW'(e1);
    if_a.e_init[(3*t+2)*EW +: EW]    = EW'(e2);
    if_a.edge_dx[(3*t+0)*EW +: EW]   = EW'(d0);
    if_a.edge_dx[(3*t+1)*EW +: EW]   = EW'(d1);
    if_a.edge_dx[(3*t+2)*EW +: EW]   = EW'(d2);
  endtask

  task automatic expect_a(input string tag, input logic [5:0] rgb, input logic hv, input logic [1:0] ht);
    chk({tag, "_rgb"}, 32'(rgb_a), 32'(rgb));
    chk({tag, "_hv"},  32'(hv_a),  32'(hv));
    chk({tag, "_ht"},  32'(ht_a),  32'(ht));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    cull_back = 1'b0;
    x_a = 10'd100; y_a = 10'd10;
    x_b = 10'd700; y_b = 10'd0;
    if_a.tri_mode = '0;  if_a.tri_color = '0; if_a.edge_dx = '0; if_a.e_init = '0;
    if_a.bar_iy = '0;    if_a.bar_iz = '0;    if_a.bar_iy_dx = '0; if_a.bar_iz_dx = '0;
    if_a.texel = 1'b0;
    if_b.tri_mode = '0;  if_b.tri_color = '0; if_b.edge_dx = '0; if_b.e_init = '0;
    if_b.bar_iy = '0;    if_b.bar_iz = '0;    if_b.bar_iy_dx = '0; if_b.bar_iz_dx = '0;
    if_b.texel = 1'b0;

    // Reset state
    set_a(0, 2'b01, 3'd6, -5, -5, -5, 0, 0, 0);
    tick; tick;
    expect_a("rst", 6'b000000, 1'b0, 2'd0);
    chk("rst_tex_u_a", 32'(if_a.tex_u), 32'd0);
    chk("rst_rgb_b", 32'(rgb_b), 32'd0);

    // Release in blanking; nothing changes until the frame reload
    reset = 1'b1;
    x_a = 10'd700; y_a = 10'd0;
    tick; tick;
    chk("blank_rgb", 32'(rgb_a), 32'd0);
    x_a = 10'd799; y_a = 10'd524;
    tick;
    chk("frame_reload_rgb", 32'(rgb_a), 32'd0);

    // Flat colour 6, all edges -5, no increments
    x_a = 10'd0; y_a = 10'd0;
    tick;
    expect_a("px0", 6'b011101, 1'b1, 2'd0);
    tick;
    for (int n = 1; n < 6; n++) begin
      x_a = 10'(n);
      tick;
      expect_a("flat_px", 6'b011101, 1'b1, 2'd0);
      tick;
    end

    // Asynchronous reset in the middle of a line
    x_a = 10'd6;
    tick;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb_a), 32'd0);
    chk("async_rst_hv", 32'(hv_a), 32'd0);
    tick;
    reset = 1'b1;
    x_a = 10'd7;
    tick;
    expect_a("post_rst_px", 6'b010101, 1'b0, 2'd0);

    // Edge reaching exactly zero is outside
    set_a(0, 2'b01, 3'd6, -1, -1, -1, 1, 0, 0);
    set_a(1, 2'b00, 3'd0, 0, 0, 0, 0, 0, 0);
    x_a = 10'd799; y_a = 10'd0;
    tick;
    x_a = 10'd0; y_a = 10'd1;
    tick;
    expect_a("edge_px0", 6'b011101, 1'b1, 2'd0);
    tick;
    chk("edge_ph0_hold", 32'(rgb_a), 32'b011101);
    x_a = 10'd1;
    tick;
    expect_a("edge_zero_px1", 6'b010101, 1'b0, 2'd0);
    tick;

    // Index priority between two front faces
    set_a(0, 2'b01, 3'd4, -5, -5, -5, 0, 0, 0);
    set_a(1, 2'b01, 3'd7, -3, -3, -3, 0, 0, 0);
    x_a = 10'd799; y_a = 10'd1;
    tick;
    x_a = 10'd0; y_a = 10'd2;
    tick;
    expect_a("prio_both", 6'b001100, 1'b1, 2'd0);
    tick;
    if_a.tri_mode[1:0] = 2'b00;
    x_a = 10'd1;
    tick;
    expect_a("prio_tri1", 6'b101110, 1'b1, 2'd1);
    tick;

    // Back faces, culling, front-over-back, reserved mode
    set_a(0, 2'b01, 3'd7, 3, 3, 3, 0, 0, 0);
    set_a(1, 2'b00, 3'd4, -2, -2, -2, 0, 0, 0);
    cull_back = 1'b0;
    x_a = 10'd799; y_a = 10'd2;
    tick;
    x_a = 10'd0; y_a = 10'd3;
    tick;
    expect_a("back", 6'b101011, 1'b1, 2'd0);
    tick;
    cull_back = 1'b1;
    x_a = 10'd1;
    tick;
    expect_a("culled", 6'b010101, 1'b0, 2'd0);
    tick;
    cull_back = 1'b0;
    if_a.tri_mode[3:2] = 2'b01;
    x_a = 10'd2;
    tick;
    expect_a("front_over_back", 6'b001100, 1'b1, 2'd1);
    tick;
    if_a.tri_mode = 4'b0011;
    x_a = 10'd3;
    tick;
    expect_a("mode11_off", 6'b010101, 1'b0, 2'd0);
    tick;

    // Textured, PIX_DIV=2
    set_a(0, 2'b10, 3'd0, -5, -5, -5, 0, 0, 0);
    set_a(1, 2'b00, 3'd0, 0, 0, 0, 0, 0, 0);
    if_a.bar_iy_dx[BW-1:0] = 22'h002000;
    if_a.texel = 1'b1;
    x_a = 10'd799; y_a = 10'd3;
    tick;
    x_a = 10'd0; y_a = 10'd4;
    tick;
    expect_a("tex_px0", 6'b001100, 1'b1, 2'd0);
    chk("tex_px0_u_stale", 32'(if_a.tex_u), 32'd0);
    tick;
    chk("tex_px0_u", 32'(if_a.tex_u), 32'd1);
    chk("tex_px0_v", 32'(if_a.tex_v), 32'd1);
    if_a.texel = 1'b0;
    x_a = 10'd1;
    tick;
    expect_a("tex_px1", 6'b000000, 1'b1, 2'd0);
    tick;
    chk("tex_px1_u", 32'(if_a.tex_u), 32'd2);
    chk("tex_px1_v", 32'(if_a.tex_v), 32'd2);
    if_a.texel = 1'b1;
    x_a = 10'd2;
    tick;
    chk("tex_px2_rgb", 32'(rgb_a), 32'b001100);
    tick;
    chk("tex_px2_u", 32'(if_a.tex_u), 32'd3);
    if_a.texel = 1'b0;
    x_a = 10'd640;
    tick; tick;
    chk("hblank_hold_rgb", 32'(rgb_a), 32'b001100);
    chk("hblank_hold_u", 32'(if_a.tex_u), 32'd3);

    // Textured, PIX_DIV=3, u = iy + iz
    if_b.tri_mode = 2'b10;
    if_b.e_init = {3{EW'(-5)}};
    if_b.bar_iy_dx = 22'h002000;
    if_b.bar_iz_dx = 22'h002000;
    if_b.texel = 1'b1;
    x_b = 10'd799; y_b = 10'd524;
    tick;
    x_b = 10'd0; y_b = 10'd0;
    tick;
    chk("b_px0_rgb", 32'(rgb_b), 32'b001100);
    chk("b_px0_hv", 32'(hv_b), 32'd1);
    tick;
    chk("b_px0_u", 32'(if_b.tex_u), 32'd2);
    chk("b_px0_v", 32'(if_b.tex_v), 32'd1);
    if_b.texel = 1'b0;
    tick;
    chk("b_mid_phase_rgb", 32'(rgb_b), 32'b001100);
    chk("b_mid_phase_u", 32'(if_b.tex_u), 32'd2);
    x_b = 10'd1;
    tick;
    chk("b_px1_rgb", 32'(rgb_b), 32'b000000);
    tick;
    chk("b_px1_u", 32'(if_b.tex_u), 32'd4);
    chk("b_px1_v", 32'(if_b.tex_v), 32'd2);
    if_b.texel = 1'b1;
    tick;
    chk("b_px1_mid_rgb", 32'(rgb_b), 32'b000000);
    x_b = 10'd2;
    tick;
    chk("b_px2_rgb", 32'(rgb_b), 32'b001100);
    chk("b_px2_ht", 32'(ht_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
